// File: rtl/proj_pool_pkg.sv
// Shared types and game constants for the projectile pool.
package proj_pool_pkg;

  typedef struct packed {
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
  } proj_t;

  localparam int         NP            = 15;
  localparam int         NPE           = 4;
  localparam logic [9:0] PROJ_X_SIZE   = 10'd3;
  localparam logic [9:0] PROJ_Y_SIZE   = 10'd8;
  localparam logic [9:0] PROJ_SPEED    = 10'd4;
  localparam logic [9:0] EPROJ_SPEED   = 10'd2;
  localparam int         FIRE_COOLDOWN = 8;
  localparam logic [9:0] Y_MAX         = 10'd479;

  // Width of a slot index; a single-slot pool still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/proj_pool_if.sv
// Request, kill, pixel query and status bundle of one projectile pool.
//
// Fire handshake: fire_req is a request that may be held; fire_ack is
// combinational in the same cycle and means the request was taken at the
// next rising edge into slot fire_slot. There is no backpressure on the
// pool's outputs; hit_vld is a one-cycle command with no acknowledge.
interface proj_pool_if #(
  parameter int N = 15
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);

  logic              fire_req;
  logic [9:0]        fire_x;
  logic [9:0]        fire_y;
  logic              fire_ack;
  logic [IW-1:0]     fire_slot;
  logic              hit_vld;
  logic [IW-1:0]     hit_idx;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              is_proj;
  logic [N-1:0]      proj_active;
  logic [10*N-1:0]   proj_x;
  logic [10*N-1:0]   proj_y;
  logic [CW-1:0]     active_count;
  logic              pool_full;

  modport master (
    output fire_req, fire_x, fire_y, hit_vld, hit_idx, DrawX, DrawY,
    input  fire_ack, fire_slot, is_proj, proj_active, proj_x, proj_y,
           active_count, pool_full
  );

  modport slave (
    input  fire_req, fire_x, fire_y, hit_vld, hit_idx, DrawX, DrawY,
    output fire_ack, fire_slot, is_proj, proj_active, proj_x, proj_y,
           active_count, pool_full
  );

endinterface

// File: rtl/proj_pool_slot.sv
// One projectile slot: load on fire, move once per frame, retire when it
// leaves the screen or is killed, and test the current pixel against it.
module proj_pool_slot
  import proj_pool_pkg::*;
#(
  parameter bit         DIR_UP = 1'b1,
  parameter logic [9:0] SPEED  = PROJ_SPEED,
  parameter logic [9:0] XSIZE  = PROJ_X_SIZE,
  parameter logic [9:0] YSIZE  = PROJ_Y_SIZE
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       load,
  input  logic [9:0] load_x,
  input  logic [9:0] load_y,
  input  logic       kill,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  output proj_t      state,
  output logic       hit
);

  logic [10:0] x_ext, y_ext, dx_ext, dy_ext;
  logic        retire;
  logic [9:0]  y_next;

  // Next position and off-screen test in 11 bits so nothing wraps.
  always_comb begin
    x_ext  = {1'b0, state.x};
    y_ext  = {1'b0, state.y};
    dx_ext = {1'b0, draw_x};
    dy_ext = {1'b0, draw_y};
    retire = 1'b0;
    y_next = state.y;
    if (DIR_UP) begin
      retire = y_ext < {1'b0, SPEED};
      y_next = state.y - SPEED;
    end else begin
      retire = (y_ext + {1'b0, SPEED} + {1'b0, YSIZE} - 11'd1) > {1'b0, Y_MAX};
      y_next = state.y + SPEED;
    end
    hit = state.active
        & (x_ext <= dx_ext) & (dx_ext < x_ext + {1'b0, XSIZE})
        & (y_ext <= dy_ext) & (dy_ext < y_ext + {1'b0, YSIZE});
  end

  // Slot register: load wins (only ever targets a free slot), then kill, then motion.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= '0;
    end else if (load) begin
      state <= '{active: 1'b1, x: load_x, y: load_y};
    end else if (kill) begin
      state.active <= 1'b0;
    end else if (frame_tick && state.active) begin
      if (retire) state.active <= 1'b0;
      else        state.y      <= y_next;
    end
  end

endmodule

// File: rtl/proj_pool.sv
// Projectile pool: N slots, lowest-free allocation with a frame cooldown,
// per-frame motion, kill by index, pixel query and population status.
module proj_pool
  import proj_pool_pkg::*;
#(
  parameter int         N        = NP,
  parameter bit         DIR_UP   = 1'b1,
  parameter logic [9:0] SPEED    = PROJ_SPEED,
  parameter int         COOLDOWN = FIRE_COOLDOWN,
  parameter logic [9:0] XSIZE    = PROJ_X_SIZE,
  parameter logic [9:0] YSIZE    = PROJ_Y_SIZE
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  proj_pool_if.slave  bus
);

  localparam int IW  = idx_width(N);
  localparam int CW  = $clog2(N + 1);
  localparam int CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  proj_t            slot_q [N];
  logic [N-1:0]     active_vec, hit_vec, load_vec, kill_vec;
  logic [10*N-1:0]  x_vec, y_vec;
  logic             free_found;
  logic [IW-1:0]    free_idx;
  logic [CW-1:0]    count;
  logic             ack;
  logic [CDW-1:0]   cd;

  // Flatten slot state into the packed status vectors.
  always_comb begin
    active_vec = '0;
    x_vec      = '0;
    y_vec      = '0;
    for (int i = 0; i < N; i++) begin
      active_vec[i]     = slot_q[i].active;
      x_vec[10*i +: 10] = slot_q[i].x;
      y_vec[10*i +: 10] = slot_q[i].y;
    end
  end

  // Lowest-index free slot, from pre-edge state only (a same-cycle kill is not seen).
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!active_vec[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // Accept, per-slot load/kill strobes and population count.
  always_comb begin
    ack      = bus.fire_req & free_found & (cd == '0) & ~Reset;
    load_vec = '0;
    kill_vec = '0;
    count    = '0;
    for (int i = 0; i < N; i++) begin
      load_vec[i] = ack && (free_idx == IW'(i));
      kill_vec[i] = bus.hit_vld && (bus.hit_idx == IW'(i));
      count       = count + CW'(active_vec[i]);
    end
  end

  // Fire cooldown: reload on accept, otherwise count frames down to zero.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                         cd <= '0;
    else if (ack)                      cd <= CDW'(COOLDOWN);
    else if (frame_tick && cd != '0)   cd <= cd - CDW'(1);
  end

  for (genvar g = 0; g < N; g++) begin : g_slot
    proj_pool_slot #(
      .DIR_UP (DIR_UP),
      .SPEED  (SPEED),
      .XSIZE  (XSIZE),
      .YSIZE  (YSIZE)
    ) u_slot (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_tick (frame_tick),
      .load       (load_vec[g]),
      .load_x     (bus.fire_x),
      .load_y     (bus.fire_y),
      .kill       (kill_vec[g]),
      .draw_x     (bus.DrawX),
      .draw_y     (bus.DrawY),
      .state      (slot_q[g]),
      .hit        (hit_vec[g])
    );
  end

  assign bus.fire_ack     = ack;
  assign bus.fire_slot    = ack ? free_idx : '0;
  assign bus.is_proj      = |hit_vec;
  assign bus.proj_active  = active_vec;
  assign bus.proj_x       = x_vec;
  assign bus.proj_y       = y_vec;
  assign bus.active_count = count;
  assign bus.pool_full    = ~free_found;

endmodule

// File: tb/tb_proj_pool.sv
// Bench for proj_pool: three pools (player default, downward enemy pool,
// four-slot pool without cooldown) driven from one sequence.
module tb_proj_pool;

  logic Clk, Reset;
  logic ft_a, ft_b, ft_c;

  proj_pool_if #(.N(15)) ifa ();
  proj_pool_if #(.N(2))  ifb ();
  proj_pool_if #(.N(4))  ifc ();

  proj_pool #(.N(15), .DIR_UP(1'b1), .SPEED(10'd4), .COOLDOWN(8)) dut_a (
    .Clk(Clk), .Reset(Reset), .frame_tick(ft_a), .bus(ifa.slave));
  proj_pool #(.N(2), .DIR_UP(1'b0), .SPEED(10'd4), .COOLDOWN(0)) dut_b (
    .Clk(Clk), .Reset(Reset), .frame_tick(ft_b), .bus(ifb.slave));
  proj_pool #(.N(4), .DIR_UP(1'b1), .SPEED(10'd4), .COOLDOWN(0)) dut_c (
    .Clk(Clk), .Reset(Reset), .frame_tick(ft_c), .bus(ifc.slave));

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [31:0] observe(input string tag);
    case (tag)
      "a_ack":  return 32'(ifa.fire_ack);
      "a_slot": return 32'(ifa.fire_slot);
      "a_act":  return 32'(ifa.proj_active);
      "a_cnt":  return 32'(ifa.active_count);
      "a_x0":   return 32'(ifa.proj_x[9:0]);
      "a_y0":   return 32'(ifa.proj_y[9:0]);
      "a_y1":   return 32'(ifa.proj_y[19:10]);
      "b_ack":  return 32'(ifb.fire_ack);
      "b_act":  return 32'(ifb.proj_active);
      "b_y0":   return 32'(ifb.proj_y[9:0]);
      "c_ack":  return 32'(ifc.fire_ack);
      "c_slot": return 32'(ifc.fire_slot);
      "c_act":  return 32'(ifc.proj_active);
      "c_cnt":  return 32'(ifc.active_count);
      "c_full": return 32'(ifc.pool_full);
      "c_isp":  return 32'(ifc.is_proj);
      default:  return 32'hdead_beef;
    endcase
  endfunction

  // scoreboard: queue an expectation when the stimulus is set up
  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  // let combinational outputs settle, then compare everything queued
  task automatic sample();
    string       t;
    logic [31:0] e;
    #1;
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, observe(t), e);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_all();
    ifa.fire_req = 0; ifa.hit_vld = 0;
    ifb.fire_req = 0; ifb.hit_vld = 0;
    ifc.fire_req = 0; ifc.hit_vld = 0;
    ft_a = 0; ft_b = 0; ft_c = 0;
  endtask

  task automatic tick_a();
    ft_a = 1; cycle(); ft_a = 0; cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1;
    idle_all();
    ifa.fire_x = 0; ifa.fire_y = 0; ifa.hit_idx = 0; ifa.DrawX = 0; ifa.DrawY = 0;
    ifb.fire_x = 0; ifb.fire_y = 0; ifb.hit_idx = 0; ifb.DrawX = 0; ifb.DrawY = 0;
    ifc.fire_x = 0; ifc.fire_y = 0; ifc.hit_idx = 0; ifc.DrawX = 0; ifc.DrawY = 0;
    cycle(); cycle();
    expect_val("a_act", 0); expect_val("a_cnt", 0); expect_val("a_ack", 0);
    expect_val("c_full", 0); expect_val("c_isp", 0);
    sample();
    Reset = 0;
    cycle();

    // ---- pool A: fire, cooldown, motion up, kill ----
    ifa.fire_req = 1; ifa.fire_x = 100; ifa.fire_y = 400;
    expect_val("a_ack", 1); expect_val("a_slot", 0);
    sample();
    cycle();
    expect_val("a_ack", 0); expect_val("a_act", 1); expect_val("a_cnt", 1);
    expect_val("a_x0", 100); expect_val("a_y0", 400);
    sample();
    ifa.fire_req = 0;
    for (int i = 0; i < 7; i++) tick_a();
    ifa.fire_req = 1;
    expect_val("a_ack", 0); expect_val("a_y0", 372);
    sample();
    ft_a = 1;
    expect_val("a_ack", 0);
    sample();
    cycle();
    ifa.fire_x = 50; ifa.fire_y = 6;
    expect_val("a_ack", 1); expect_val("a_slot", 1); expect_val("a_y0", 368);
    sample();
    cycle();
    ifa.fire_req = 0; ft_a = 0;
    expect_val("a_y1", 6); expect_val("a_y0", 364);
    expect_val("a_act", 3); expect_val("a_cnt", 2);
    sample();
    ifa.hit_vld = 1; ifa.hit_idx = 0;
    cycle();
    ifa.hit_idx = 15; ft_a = 1;
    expect_val("a_act", 2); expect_val("a_cnt", 1);
    sample();
    cycle();
    ifa.hit_vld = 0; ft_a = 0;
    expect_val("a_y1", 2); expect_val("a_act", 2); expect_val("a_cnt", 1);
    sample();
    tick_a();
    expect_val("a_act", 0); expect_val("a_cnt", 0);
    sample();
    tick_a();

    // ---- pool B: downward edge of screen ----
    ifb.fire_req = 1; ifb.fire_x = 10; ifb.fire_y = 468;
    expect_val("b_ack", 1);
    sample();
    cycle();
    ifb.fire_req = 0;
    expect_val("b_act", 1); expect_val("b_y0", 468);
    sample();
    ft_b = 1; cycle(); ft_b = 0;
    expect_val("b_act", 1); expect_val("b_y0", 472);
    sample();
    ft_b = 1; cycle(); ft_b = 0;
    expect_val("b_act", 0);
    sample();

    // ---- pool C: fill, full, kill+fire, pixel query ----
    for (int i = 0; i < 4; i++) begin
      ifc.fire_req = 1;
      ifc.fire_x = (i == 0) ? 10'd200 : 10'(400 + 10 * i);
      ifc.fire_y = (i == 0) ? 10'd300 : 10'd100;
      expect_val("c_ack", 1); expect_val("c_slot", 32'(i));
      sample();
      cycle();
    end
    expect_val("c_full", 1); expect_val("c_cnt", 4); expect_val("c_act", 15);
    expect_val("c_ack", 0);
    sample();
    ifc.hit_vld = 1; ifc.hit_idx = 2;
    expect_val("c_ack", 0); expect_val("c_slot", 0);
    sample();
    cycle();
    ifc.hit_vld = 0; ifc.fire_x = 400; ifc.fire_y = 150;
    expect_val("c_ack", 1); expect_val("c_slot", 2);
    expect_val("c_full", 0); expect_val("c_cnt", 3);
    sample();
    cycle();
    ifc.fire_req = 0;
    expect_val("c_act", 15); expect_val("c_cnt", 4);
    sample();
    ifc.DrawX = 202; ifc.DrawY = 307; expect_val("c_isp", 1); sample();
    ifc.DrawX = 203; ifc.DrawY = 307; expect_val("c_isp", 0); sample();
    ifc.DrawX = 202; ifc.DrawY = 308; expect_val("c_isp", 0); sample();
    ifc.DrawX = 200; ifc.DrawY = 300; expect_val("c_isp", 1); sample();
    ifc.DrawX = 199; ifc.DrawY = 300; expect_val("c_isp", 0); sample();
    ifc.DrawX = $urandom_range(0, 199); ifc.DrawY = $urandom_range(0, 99);
    expect_val("c_isp", 0); sample();
    ifc.hit_vld = 1; ifc.hit_idx = 3;
    cycle();
    ifc.hit_vld = 0;
    expect_val("c_cnt", 3); expect_val("c_act", 7);
    sample();

    // ---- asynchronous reset mid-flight (A cooldown is 5 here) ----
    ifa.fire_req = 1; ifa.fire_x = 20; ifa.fire_y = 200;
    expect_val("a_ack", 0);
    sample();
    Reset = 1;
    expect_val("c_act", 0); expect_val("c_cnt", 0); expect_val("a_ack", 0);
    sample();
    cycle(); cycle();
    Reset = 0;
    expect_val("a_ack", 1); expect_val("a_slot", 0);
    sample();
    cycle();
    ifa.fire_req = 0;
    expect_val("a_act", 1); expect_val("a_y0", 200);
    sample();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
